// File: rtl/log2_stream_pkg.sv
// Shared widths, pipeline stage record and fraction-LUT generator for log2_stream.
package log2_stream_pkg;

    localparam int DIN_W    = 24;
    localparam int FRAC_IN  = 8;
    localparam int LUT_AW   = 6;
    localparam int FRAC_OUT = 8;
    localparam int IW       = 4;
    localparam int TAG_W    = 3;

    function automatic int calc_int_w(input int din_w, input int frac_in);
        return $clog2(din_w - frac_in);
    endfunction

    localparam int INT_W  = calc_int_w(DIN_W, FRAC_IN);
    localparam int DOUT_W = INT_W + FRAC_OUT;
    localparam int LUT_N  = 1 << LUT_AW;

    // round(log2(1 + idx/LUT_N) * 2^FRAC_OUT), clipped so it always fits FRAC_OUT bits
    function automatic int lut_entry(input int idx);
        real x;
        real v;
        int  r;
        x = 1.0 + real'(idx) / real'(LUT_N);
        v = $ln(x) / $ln(2.0) * real'(1 << FRAC_OUT);
        r = $rtoi(v + 0.5);
        if (r > (1 << FRAC_OUT) - 1) r = (1 << FRAC_OUT) - 1;
        return r;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [DIN_W-1:0]  data;
        logic [INT_W-1:0]  e;
        logic [LUT_AW-1:0] addr;
        logic [IW-1:0]     w;
        logic [TAG_W-1:0]  tag;
        logic              uf;
    } stage_t;

endpackage

// File: rtl/log2_stream_if.sv
// Valid/ready stream bundle for log2_stream: magnitude plus tag in, log2 code plus tag out.
interface log2_stream_if;
    import log2_stream_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_uf;

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_uf
    );

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_uf
    );

endinterface

// File: rtl/log2_stream_penc.sv
// Combinational leading-one encoder: position of the highest set bit, plus an any-set flag.
module log2_stream_penc #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] pos,
    output logic             any
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (din[i]) pos = OUT_W'(i);
        end
    end

    assign any = |din;

endmodule

// File: rtl/log2_stream.sv
// Pipelined log2 with one global stall enable. Define LOG2_STREAM_INTERP_EN to add
// a fourth stage that linearly interpolates between adjacent LUT entries.
module log2_stream
    import log2_stream_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    log2_stream_if.slave bus
);

    localparam int SH_W    = $clog2(DIN_W);
    localparam int TOP_INT = DIN_W - 1 - FRAC_IN;

    stage_t              s1_reg;
    stage_t              s2_reg;
    logic                out_valid_reg;
    logic [DOUT_W-1:0]   out_data_reg;
    logic [TAG_W-1:0]    out_tag_reg;
    logic                out_uf_reg;
    logic                adv;
    logic [INT_W-1:0]    e_in;
    logic                any_in;
    logic [SH_W-1:0]     sh;
    logic [DIN_W-1:0]    shifted;
    logic [FRAC_OUT-1:0] lut [LUT_N];

    assign adv          = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_tag   = out_tag_reg;
    assign bus.out_uf    = out_uf_reg;

    log2_stream_penc #(
        .IN_W  (DIN_W - FRAC_IN),
        .OUT_W (INT_W)
    ) u_penc (
        .din (bus.in_data[DIN_W-1:FRAC_IN]),
        .pos (e_in),
        .any (any_in)
    );

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        assign lut[gi] = FRAC_OUT'(lut_entry(gi));
    end

    // Normalise so the leading one sits at the MSB; vacated low bits fill with zero.
    assign sh      = SH_W'(TOP_INT) - SH_W'(s1_reg.e);
    assign shifted = s1_reg.data << sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else if (adv) begin
            s1_reg.valid <= bus.in_valid;
            s1_reg.data  <= bus.in_data;
            s1_reg.e     <= e_in;
            s1_reg.addr  <= '0;
            s1_reg.w     <= '0;
            s1_reg.tag   <= bus.in_tag;
            s1_reg.uf    <= !any_in;
            s2_reg       <= s1_reg;
            s2_reg.addr  <= shifted[DIN_W-2 -: LUT_AW];
            s2_reg.w     <= shifted[DIN_W-2-LUT_AW -: IW];
        end
    end

`ifdef LOG2_STREAM_INTERP_EN
    localparam logic [FRAC_OUT:0] FULL_SCALE = {1'b1, {FRAC_OUT{1'b0}}};

    stage_t               s3_reg;
    logic [FRAC_OUT:0]    lo_reg;
    logic [FRAC_OUT:0]    hi_reg;
    logic [FRAC_OUT:0]    diff;
    logic [FRAC_OUT+IW:0] prod;
    logic [FRAC_OUT:0]    step;
    logic [FRAC_OUT+1:0]  sum;
    logic [FRAC_OUT-1:0]  frac;
    logic                 unused_bits;

    assign diff = hi_reg - lo_reg;
    assign prod = {{IW{1'b0}}, diff} * {{(FRAC_OUT+1){1'b0}}, s3_reg.w};
    assign step = prod[FRAC_OUT+IW:IW];
    assign sum  = {1'b0, lo_reg} + {1'b0, step};
    assign frac = (|sum[FRAC_OUT+1:FRAC_OUT]) ? '1 : sum[FRAC_OUT-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_reg        <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_tag_reg   <= '0;
            out_uf_reg    <= 1'b0;
        end else if (adv) begin
            s3_reg <= s2_reg;
            lo_reg <= {1'b0, lut[s2_reg.addr]};
            // The entry past the table end is exactly 1.0 in output fraction units.
            hi_reg <= (s2_reg.addr == '1) ? FULL_SCALE
                                          : {1'b0, lut[s2_reg.addr + LUT_AW'(1)]};
            out_valid_reg <= s3_reg.valid;
            out_tag_reg   <= s3_reg.tag;
            out_uf_reg    <= s3_reg.uf;
            out_data_reg  <= s3_reg.uf ? '0 : {s3_reg.e, frac};
        end
    end

    assign unused_bits = ^{s3_reg.data, s3_reg.addr, prod[IW-1:0],
                           shifted[DIN_W-1], shifted[DIN_W-2-LUT_AW-IW:0]};
`else
    logic unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_tag_reg   <= '0;
            out_uf_reg    <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= s2_reg.valid;
            out_tag_reg   <= s2_reg.tag;
            out_uf_reg    <= s2_reg.uf;
            out_data_reg  <= s2_reg.uf ? '0 : {s2_reg.e, lut[s2_reg.addr]};
        end
    end

    assign unused_bits = ^{s2_reg.data, s2_reg.w,
                           shifted[DIN_W-1], shifted[DIN_W-2-LUT_AW-IW:0]};
`endif

endmodule
